xge_rx_pkt_fifo: RTL

XGE_RX_PKT_FIFO -- requirements
Module: xge_rx_pkt_fifo

---
 rtl/xge_rx_pkt_fifo_pkg.sv | 29 ++
 rtl/xge_pkt_ram.sv | 23 ++
 rtl/xge_rx_pkt_fifo.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/xge_rx_pkt_fifo_pkg.sv
// Shared encodings for the rx packet FIFO: write-side FSM states and the
// bit layout of one stored word (LSB first: data, keep, last, user).
package xge_rx_pkt_fifo_pkg;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_RUN  = 2'd1,
    ST_DROP = 2'd2
  } wr_state_e;

  localparam int DATA_LSB = 0;

  function automatic int keep_lsb(input int dw);
    return dw;
  endfunction

  function automatic int last_bit(input int dw);
    return dw + dw / 8;
  endfunction

  function automatic int user_bit(input int dw);
    return dw + dw / 8 + 1;
  endfunction

  function automatic int word_w(input int dw);
    return dw + dw / 8 + 2;
  endfunction

endpackage

// File: rtl/xge_pkt_ram.sv
// Simple dual-port frame store, one write and one registered read per clk; read latency 1.
// No flow control: rd_dat holds its last value whenever rd_en is low.
module xge_pkt_ram #(
  parameter int AW = 9,
  parameter int W  = 74
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_dat
);

  logic [W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/xge_rx_pkt_fifo.sv
// Rx packet FIFO: only whole committed frames reach the user; commit-to-valid latency 2 cycles.
// No backpressure to the MAC (overflow/bad frames dropped and counted); user side is AXIS valid/ready.
module xge_rx_pkt_fifo
  import xge_rx_pkt_fifo_pkg::*;
#(
  parameter int AW       = 9,
  parameter int DW       = 64,
  parameter int DROP_BAD = 1,
  parameter int CW       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   s_axis_tdata,
  input  logic [DW/8-1:0] s_axis_tkeep,
  input  logic            s_axis_tvalid,
  input  logic            s_axis_tlast,
  input  logic            s_axis_tuser,
  output logic [DW-1:0]   m_axis_tdata,
  output logic [DW/8-1:0] m_axis_tkeep,
  output logic            m_axis_tvalid,
  output logic            m_axis_tlast,
  output logic            m_axis_tuser,
  input  logic            m_axis_tready,
  output logic [AW:0]     fill,
  output logic [CW-1:0]   ovf_drop_cnt,
  output logic [CW-1:0]   bad_drop_cnt
);

  localparam int KW       = DW / 8;
  localparam int WW       = word_w(DW);
  localparam int KEEP_LSB = keep_lsb(DW);
  localparam int LAST_BIT = last_bit(DW);
  localparam int USER_BIT = user_bit(DW);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] DEPTH   = PTR_ONE << AW;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  wr_state_e     state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, prod_ptr_q, prod_ptr_d;
  logic [AW:0]   rd_ptr_q, cons_ptr_q, cons_ptr_d, fill_q;
  logic [CW-1:0] ovf_cnt_q, ovf_cnt_d, bad_cnt_q, bad_cnt_d;
  logic          has_space, frame_ok, wr_en;
  logic [WW-1:0] wr_dat, ram_dat, skid_dat, out_dat;
  logic          ram_vld, skid_vld, out_vld, rd_en, pop;

  assign has_space = (wr_ptr_q - cons_ptr_q) < DEPTH;
  assign frame_ok  = s_axis_tuser || (DROP_BAD == 0);

  // Only the tlast word carries the frame status; earlier words store user=0.
  always_comb begin
    wr_dat = '0;
    wr_dat[DATA_LSB +: DW] = s_axis_tdata;
    wr_dat[KEEP_LSB +: KW] = s_axis_tkeep;
    wr_dat[LAST_BIT]       = s_axis_tlast;
    wr_dat[USER_BIT]       = s_axis_tlast && s_axis_tuser;
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    prod_ptr_d = prod_ptr_q;
    ovf_cnt_d  = ovf_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    wr_en      = 1'b0;
    case (state_q)
      ST_SYNC: if (s_axis_tvalid && s_axis_tlast) state_d = ST_RUN;
      ST_RUN: begin
        if (s_axis_tvalid) begin
          if (!has_space) begin
            wr_ptr_d = prod_ptr_q;
            if (ovf_cnt_q != CNT_MAX) ovf_cnt_d = ovf_cnt_q + CNT_ONE;
            if (!s_axis_tlast) state_d = ST_DROP;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (s_axis_tlast) begin
              if (frame_ok) begin
                prod_ptr_d = wr_ptr_q + PTR_ONE;
              end else begin
                wr_ptr_d = prod_ptr_q;
                if (bad_cnt_q != CNT_MAX) bad_cnt_d = bad_cnt_q + CNT_ONE;
              end
            end
          end
        end
      end
      ST_DROP: if (s_axis_tvalid && s_axis_tlast) state_d = ST_RUN;
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SYNC;
      wr_ptr_q   <= '0;
      prod_ptr_q <= '0;
      ovf_cnt_q  <= '0;
      bad_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      prod_ptr_q <= prod_ptr_d;
      ovf_cnt_q  <= ovf_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  xge_pkt_ram #(.AW(AW), .W(WW)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_dat  (wr_dat),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_dat  (ram_dat)
  );

  // The skid keeps m_axis_tready off the RAM enable: a new read is issued
  // whenever the skid is empty, and a stalled RAM word is parked in the skid.
  assign out_vld    = skid_vld || ram_vld;
  assign out_dat    = skid_vld ? skid_dat : ram_dat;
  assign pop        = out_vld && m_axis_tready;
  assign rd_en      = (rd_ptr_q != prod_ptr_q) && !skid_vld;
  assign cons_ptr_d = pop ? cons_ptr_q + PTR_ONE : cons_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      cons_ptr_q <= '0;
      fill_q     <= '0;
      ram_vld    <= 1'b0;
      skid_vld   <= 1'b0;
    end else begin
      cons_ptr_q <= cons_ptr_d;
      fill_q     <= prod_ptr_d - cons_ptr_d;
      if (rd_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (skid_vld) begin
        if (pop) skid_vld <= 1'b0;
      end else if (rd_en) begin
        ram_vld <= 1'b1;
        if (ram_vld && !pop) skid_vld <= 1'b1;
      end else if (pop) begin
        ram_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!skid_vld) skid_dat <= ram_dat;
  end

  assign m_axis_tvalid = out_vld;
  assign m_axis_tdata  = out_dat[DATA_LSB +: DW];
  assign m_axis_tkeep  = out_dat[KEEP_LSB +: KW];
  assign m_axis_tlast  = out_vld && out_dat[LAST_BIT];
  assign m_axis_tuser  = out_vld && out_dat[USER_BIT];
  assign fill          = fill_q;
  assign ovf_drop_cnt  = ovf_cnt_q;
  assign bad_drop_cnt  = bad_cnt_q;

endmodule
